// File: rtl/trap_seq.sv
// Trap entry sequencer: captures an exception, writes mepc/mcause/mtval/mstatus
// one CSR per cycle, then pulses a fetch redirect to the trap handler.
module trap_seq #(
    parameter bit MTVAL_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_valid,
    output logic        exc_ready,
    input  logic [31:0] exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic [31:0] mstatus_in,
    input  logic [31:0] mtvec_in,
    input  logic        pipe_wr_csr_n,
    input  logic [11:0] pipe_csr_wr_addr,
    input  logic [31:0] pipe_csr_data,
    input  logic        is_mret_in,
    output logic        wr_csr_n,
    output logic [11:0] csr_wr_addr,
    output logic [31:0] csr_data_in,
    output logic        is_mret,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    typedef enum logic [2:0] {
        IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, REDIRECT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] epc_q, cause_q, tval_q, mstatus_q, mtvec_q;
    logic        accept;
    logic [31:0] mstatus_wr;
    logic [31:0] handler_pc;

    assign accept = (state_q == IDLE) && exc_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            epc_q     <= '0;
            cause_q   <= '0;
            tval_q    <= '0;
            mstatus_q <= '0;
            mtvec_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                epc_q     <= exc_pc;
                cause_q   <= exc_cause;
                tval_q    <= exc_tval;
                mstatus_q <= mstatus_in;
                mtvec_q   <= mtvec_in;
            end
        end
    end

    // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M-mode.
    always_comb begin
        mstatus_wr        = mstatus_q;
        mstatus_wr[7]     = mstatus_q[3];
        mstatus_wr[3]     = 1'b0;
        mstatus_wr[12:11] = 2'b11;
    end

    // Vectored mode offsets only interrupts; the shift drops cause bit 30 (32-bit wrap).
    always_comb begin
        handler_pc = {mtvec_q[31:2], 2'b00};
        if (mtvec_q[1:0] == 2'b01 && cause_q[31])
            handler_pc = handler_pc + {cause_q[29:0], 2'b00};
    end

    always_comb begin
        state_d        = state_q;
        exc_ready      = 1'b0;
        wr_csr_n       = 1'b1;
        csr_wr_addr    = '0;
        csr_data_in    = '0;
        is_mret        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        unique case (state_q)
            IDLE: begin
                exc_ready = 1'b1;
                if (exc_valid) begin
                    state_d = W_MEPC;
                end else begin
                    is_mret = is_mret_in;
                    if (!pipe_wr_csr_n) begin
                        wr_csr_n    = 1'b0;
                        csr_wr_addr = pipe_csr_wr_addr;
                        csr_data_in = pipe_csr_data;
                    end
                end
            end
            W_MEPC: begin
                wr_csr_n    = 1'b0;
                csr_wr_addr = CSR_MEPC;
                csr_data_in = epc_q;
                state_d     = W_MCAUSE;
            end
            W_MCAUSE: begin
                wr_csr_n    = 1'b0;
                csr_wr_addr = CSR_MCAUSE;
                csr_data_in = cause_q;
                state_d     = MTVAL_EN ? W_MTVAL : W_MSTATUS;
            end
            W_MTVAL: begin
                wr_csr_n    = 1'b0;
                csr_wr_addr = CSR_MTVAL;
                csr_data_in = tval_q;
                state_d     = W_MSTATUS;
            end
            W_MSTATUS: begin
                wr_csr_n    = 1'b0;
                csr_wr_addr = CSR_MSTATUS;
                csr_data_in = mstatus_wr;
                state_d     = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = handler_pc;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall = (state_q != IDLE);
endmodule

// File: doc/trap_seq.md
TRAP_SEQ -- requirements
Module: trap_seq

Interface
REQ-001 Parameter MTVAL_EN, default 1, meaning: 1 = sequence writes mtval; 0 = W_MTVAL state skipped.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 exc_valid  input  1  exception/interrupt request; held until accepted.
REQ-005 exc_ready  output  1  request accepted when exc_valid && exc_ready.
REQ-006 exc_cause  input  32  mcause value; bit31 = interrupt.
REQ-007 exc_pc  input  32  faulting PC, becomes mepc.
REQ-008 exc_tval  input  32  becomes mtval.
REQ-009 mstatus_in  input  32  current mstatus from CSR file.
REQ-010 mtvec_in  input  32  current mtvec from CSR file.
REQ-011 pipe_wr_csr_n  input  1  pipeline CSR write request, active-low.
REQ-012 pipe_csr_wr_addr  input  12  pipeline CSR write address.
REQ-013 pipe_csr_data  input  32  pipeline CSR write data.
REQ-014 is_mret_in  input  1  pipeline MRET request.
REQ-015 wr_csr_n  output  1  CSR file write enable, active-low.
REQ-016 csr_wr_addr  output  12  CSR file write address.
REQ-017 csr_data_in  output  32  CSR file write data.
REQ-018 is_mret  output  1  MRET forwarded to CSR file.
REQ-019 stall  output  1  pipeline must hold; high whenever state != IDLE.
REQ-020 redirect_valid  output  1  one-cycle fetch redirect pulse.
REQ-021 redirect_pc  output  32  trap handler target.

Function
REQ-022 FSM states SHALL be IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, REDIRECT.
REQ-023 exc_ready SHALL be 1 only in IDLE.
REQ-024 On acceptance, exc_pc, exc_cause, exc_tval, mstatus_in and mtvec_in SHALL be captured; IDLE -> W_MEPC.
REQ-025 Transitions: W_MEPC -> W_MCAUSE -> W_MTVAL (MTVAL_EN=1) or W_MSTATUS (MTVAL_EN=0); W_MTVAL -> W_MSTATUS -> REDIRECT -> IDLE; unconditional, one cycle each.
REQ-026 Each W_* state SHALL drive wr_csr_n=0 with addr 0x341/0x342/0x343/0x300 and the captured data respectively.
REQ-027 mstatus write data: captured mstatus with bit7(MPIE)=captured bit3(MIE), bit3=0, bits12:11(MPP)=2'b11; other bits unchanged.
REQ-028 In REDIRECT, redirect_valid=1 and redirect_pc={mtvec[31:2],2'b00}, plus cause[30:0]<<2 when mtvec[1:0]==1 and cause[31]==1 (32-bit wrap).
REQ-029 redirect_pc SHALL be 0 whenever redirect_valid=0.
REQ-030 In IDLE with no exc_valid, pipeline write SHALL pass through combinationally (wr_csr_n, addr, data = pipe_*).
REQ-031 In IDLE, exc_valid=1 and pipe_wr_csr_n=0 in the same cycle: exception wins, pipeline write dropped (wr_csr_n=1 that cycle).
REQ-032 is_mret = is_mret_in && IDLE && !exc_valid; MRET coincident with exception is dropped.
REQ-033 Outside IDLE, pipeline writes and MRET SHALL be ignored; no write other than sequence writes reaches the CSR file.
REQ-034 exc_valid while busy SHALL not be accepted or queued; accepted in the IDLE cycle after REDIRECT if still held.
REQ-035 Latency: accept at cycle T -> mepc write T+1, mcause T+2, mtval T+3, mstatus T+4, redirect T+5, exc_ready T+6 (each minus one when MTVAL_EN=0).

Reset
REQ-036 rst_n=0 SHALL asynchronously force IDLE and clear all captured registers to 0, at any state including mid-sequence.
REQ-037 Output values during and after reset with no input activity: wr_csr_n=1, csr_wr_addr=0, csr_data_in=0, is_mret=0, stall=0, redirect_valid=0, redirect_pc=0, exc_ready=1.
REQ-038 An aborted sequence SHALL NOT resume after reset release.

Verification
REQ-039 exc_pc=0x100, cause=2, tval=0xDEAD, mstatus=0x8, mtvec=0x2000 -> writes 341<-0x100, 342<-2, 343<-0xDEAD, 300<-0x1880; redirect_pc=0x2000 at T+5.
REQ-040 cause=0x80000007, mtvec=0x2001 -> redirect_pc=0x201C.
REQ-041 IDLE pipe write 0x340<-0x55 with exc_valid=0 -> same-cycle wr_csr_n=0, addr 0x340, data 0x55; same with exc_valid=1 -> write dropped, W_MEPC next.
REQ-042 Pipe write and is_mret_in asserted during W_MCAUSE -> no extra write, is_mret=0, stall=1.
REQ-043 rst_n low during W_MTVAL -> immediate IDLE, wr_csr_n=1; no mstatus write after release.
REQ-044 MTVAL_EN=0 -> no 0x343 write; redirect at T+4.
